// File: rtl/pixel_point_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pixel_point_fetch : coordinate -> frame-buffer read -> 1-bit pixel  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pixel_point_fetch #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int THRESH    = 128,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pt_req,
  input  logic [9:0]        coordinate_x,
  input  logic [9:0]        coordinate_y,
  output logic              Ans_valid,
  output logic              pt_pixl_value,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_CALC = 3'd1;
  localparam logic [2:0] c_REQ  = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_RESP = 3'd4;
  localparam logic [7:0] c_TMO  = 8'(TIMEOUT);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_armed;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [7:0]        r_tmo_cnt;
  logic              r_ans_valid;
  logic              r_pix;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_tmo_err;
  logic              w_oob;
  logic              w_black;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr_lin;

  assign w_oob      = (32'(r_x) >= 32'(IMG_W)) || (32'(r_y) >= 32'(IMG_H));
  assign w_black    = (32'(rd_data) < 32'(THRESH));
  assign w_accept   = pt_req && r_armed;
  assign w_addr_lin = ADDR_W'(BASE_ADDR) + ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_CALC;
      c_CALC:  w_state_nxt = w_oob ? c_RESP : c_REQ;
      c_REQ:   if (rd_ack) w_state_nxt = rd_valid ? c_RESP : c_WAIT;
      c_WAIT:  if (rd_valid || (r_tmo_cnt == c_TMO)) w_state_nxt = c_RESP;
      c_RESP:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_armed     <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_tmo_cnt   <= '0;
      r_ans_valid <= 1'b0;
      r_pix       <= 1'b0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != c_IDLE);
      r_ans_valid <= (w_state_nxt == c_RESP);
      // Re-arming only on a low pt_req stops a still-held request being taken twice
      if (!pt_req) begin
        r_armed <= 1'b1;
      end else if ((r_state == c_IDLE) && r_armed) begin
        r_armed <= 1'b0;
      end
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_x <= coordinate_x;
            r_y <= coordinate_y;
          end
        end
        c_CALC: begin
          r_rd_addr <= w_addr_lin;
          if (w_oob) r_pix <= 1'b0;
          else       r_rd_req <= 1'b1;
        end
        c_REQ: begin
          if (rd_ack) begin
            r_rd_req <= 1'b0;
            if (rd_valid) r_pix <= w_black;
          end
        end
        c_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (rd_valid) begin
            r_pix <= w_black;
          end else if (r_tmo_cnt == c_TMO) begin
            r_pix     <= 1'b0;
            r_tmo_err <= 1'b1;
          end
        end
        c_RESP:  r_tmo_cnt <= '0;
        default: r_tmo_cnt <= '0;
      endcase
    end
  end

  assign Ans_valid     = r_ans_valid;
  assign pt_pixl_value = r_pix;
  assign rd_req        = r_rd_req;
  assign rd_addr       = r_rd_addr;
  assign busy          = r_busy;
  assign timeout_err   = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_point_fetch.sv
`default_nettype none
// Bench for pixel_point_fetch: directed scenarios plus randomised reads against
// an arithmetic model of address, latency and binarisation.
module tb_pixel_point_fetch;

  logic        clk;
  logic        rst;
  logic        pt_req;
  logic [9:0]  coordinate_x;
  logic [9:0]  coordinate_y;
  logic        Ans_valid;
  logic        pt_pixl_value;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        busy;
  logic        timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_xfer = 0;
  int n_ans  = 0;
  int n_acc  = 0;
  logic busy_q = 1'b0;

  typedef struct {
    int          ans_cyc;
    int          ans_cnt;
    logic        pix;
    int          req_cyc;
    int          req_cnt;
    logic [18:0] addr;
    bit          stable;
  } res_t;

  pixel_point_fetch dut (
    .clk(clk), .rst(rst), .pt_req(pt_req),
    .coordinate_x(coordinate_x), .coordinate_y(coordinate_y),
    .Ans_valid(Ans_valid), .pt_pixl_value(pt_pixl_value),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (rd_req && rd_ack) n_xfer++;
      if (Ans_valid) n_ans++;
      if (busy && !busy_q) n_acc++;
    end
    busy_q = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // One request, acting as requester and arbiter. Called just after a posedge;
  // cycle 0 is the cycle pt_req first goes high.
  task automatic do_txn(input logic [9:0] x, input logic [9:0] y, input int ack_dly,
                        input int vld_dly, input logic [7:0] data, input int hold_extra,
                        input int low_cycles, input int early_drop, output res_t r);
    int ack_cyc, hi_cnt, drop_cyc;
    r.ans_cyc = -1; r.ans_cnt = 0; r.pix = 1'b0; r.req_cyc = -1; r.req_cnt = 0;
    r.addr = '0; r.stable = 1'b1;
    ack_cyc = -1; hi_cnt = 0; drop_cyc = -1;
    coordinate_x = x; coordinate_y = y; pt_req = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((early_drop >= 0 && cyc >= early_drop) || (drop_cyc >= 0 && cyc >= drop_cyc))
        pt_req = 1'b0;
      rd_ack = 1'b0; rd_valid = 1'b0;
      if (rd_req === 1'b1 && ack_cyc < 0) begin
        if (hi_cnt == ack_dly) begin rd_ack = 1'b1; ack_cyc = cyc; end
        hi_cnt++;
      end
      if (ack_cyc >= 0 && vld_dly >= 0 && cyc == ack_cyc + vld_dly) begin
        rd_valid = 1'b1; rd_data = data;
      end
      @(negedge clk);
      if (rd_req === 1'b1) begin
        if (r.req_cyc < 0) begin r.req_cyc = cyc; r.addr = rd_addr; end
        else if (rd_addr !== r.addr) r.stable = 1'b0;
        r.req_cnt++;
      end
      if (Ans_valid === 1'b1) begin
        r.ans_cnt++;
        if (r.ans_cyc < 0) begin
          r.ans_cyc = cyc; r.pix = pt_pixl_value; drop_cyc = cyc + 1 + hold_extra;
        end
      end
      @(posedge clk); #1;
      if (drop_cyc >= 0 && cyc >= drop_cyc + low_cycles - 1) break;
    end
    pt_req = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pt_req = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    coordinate_x = '0; coordinate_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({Ans_valid, pt_pixl_value, rd_req, busy, timeout_err} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {Ans_valid, pt_pixl_value, rd_req, busy, timeout_err}); else n_pass++;
    n_chk++; if (rd_addr !== 19'd0)
      $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    res_t r;
    do_txn(10'd110, 10'd114, 0, 3, 8'h20, 0, 2, -1, r);
    n_chk++; if (r.req_cyc !== 2) $display("FAIL basic_req_cycle: got %0d expected 2", r.req_cyc); else n_pass++;
    n_chk++; if (r.req_cnt !== 1) $display("FAIL basic_req_len: got %0d expected 1", r.req_cnt); else n_pass++;
    n_chk++; if (r.addr !== 19'd73070) $display("FAIL basic_addr: got %0d expected 73070", r.addr); else n_pass++;
    n_chk++; if (r.ans_cyc !== 6) $display("FAIL basic_ans_cycle: got %0d expected 6", r.ans_cyc); else n_pass++;
    n_chk++; if (r.pix !== 1'b1) $display("FAIL basic_pixel: got %b expected 1", r.pix); else n_pass++;
    n_chk++; if (r.ans_cnt !== 1) $display("FAIL basic_ans_pulses: got %0d expected 1", r.ans_cnt); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_threshold();
    res_t r;
    do_txn(10'd3, 10'd7, 1, 0, 8'd127, 0, 2, -1, r);
    n_chk++; if (r.pix !== 1'b1) $display("FAIL thresh_127: got %b expected 1", r.pix); else n_pass++;
    n_chk++; if (r.ans_cyc !== 4) $display("FAIL thresh_same_cycle_valid: got %0d expected 4", r.ans_cyc); else n_pass++;
    @(negedge clk);
    n_chk++; if (pt_pixl_value !== 1'b1) $display("FAIL thresh_hold_1: got %b expected 1", pt_pixl_value); else n_pass++;
    @(posedge clk); #1;
    do_txn(10'd639, 10'd479, 0, 2, 8'd128, 0, 2, -1, r);
    n_chk++; if (r.pix !== 1'b0) $display("FAIL thresh_128: got %b expected 0", r.pix); else n_pass++;
    n_chk++; if (r.addr !== 19'd307199) $display("FAIL thresh_corner_addr: got %0d expected 307199", r.addr); else n_pass++;
    @(negedge clk);
    n_chk++; if (pt_pixl_value !== 1'b0) $display("FAIL thresh_hold_0: got %b expected 0", pt_pixl_value); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rearm();
    res_t r;
    int acc0, xfer0, ans0;
    acc0 = n_acc; xfer0 = n_xfer; ans0 = n_ans;
    do_txn(10'd20, 10'd30, 0, 1, 8'd5, 1, 1, -1, r);
    n_chk++; if (r.req_cnt !== 1) $display("FAIL rearm_first_reqs: got %0d expected 1", r.req_cnt); else n_pass++;
    n_chk++; if (r.ans_cnt !== 1) $display("FAIL rearm_first_ans: got %0d expected 1", r.ans_cnt); else n_pass++;
    do_txn(10'd21, 10'd30, 0, 1, 8'd200, 0, 2, -1, r);
    n_chk++; if (r.req_cyc !== 2) $display("FAIL rearm_second_req_cycle: got %0d expected 2", r.req_cyc); else n_pass++;
    n_chk++; if (r.ans_cyc !== 4) $display("FAIL rearm_second_ans_cycle: got %0d expected 4", r.ans_cyc); else n_pass++;
    n_chk++; if (n_acc - acc0 !== 2) $display("FAIL rearm_accepts: got %0d expected 2", n_acc - acc0); else n_pass++;
    n_chk++; if (n_xfer - xfer0 !== n_ans - ans0) $display("FAIL rearm_ans_vs_xfer: got %0d answers for %0d transfers", n_ans - ans0, n_xfer - xfer0); else n_pass++;
  endtask

  task automatic test_out_of_range();
    res_t r;
    logic [9:0] ys [2];
    logic [9:0] xs [2];
    xs[0] = 10'd700; ys[0] = 10'd10;
    xs[1] = 10'd5;   ys[1] = 10'd480;
    for (int i = 0; i < 2; i++) begin
      do_txn(10'd1, 10'd1, 0, 0, 8'd0, 0, 2, -1, r);
      n_chk++; if (r.pix !== 1'b1) $display("FAIL oob_prep_%0d: got %b expected 1", i, r.pix); else n_pass++;
      do_txn(xs[i], ys[i], 0, 0, 8'd0, 0, 2, -1, r);
      n_chk++; if (r.req_cnt !== 0) $display("FAIL oob_no_read_%0d: got %0d read cycles expected 0", i, r.req_cnt); else n_pass++;
      n_chk++; if (r.ans_cyc !== 2) $display("FAIL oob_ans_cycle_%0d: got %0d expected 2", i, r.ans_cyc); else n_pass++;
      n_chk++; if (r.pix !== 1'b0) $display("FAIL oob_pixel_%0d: got %b expected 0", i, r.pix); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    res_t r;
    do_txn(10'd50, 10'd60, 0, 1, 8'd0, 0, 2, -1, r);
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_clear_before: got %b expected 0", timeout_err); else n_pass++;
    do_txn(10'd51, 10'd60, 0, -1, 8'd0, 0, 2, -1, r);
    n_chk++; if (r.ans_cyc !== 259) $display("FAIL tmo_ans_cycle: got %0d expected 259", r.ans_cyc); else n_pass++;
    n_chk++; if (r.pix !== 1'b0) $display("FAIL tmo_pixel: got %b expected 0", r.pix); else n_pass++;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_flag: got %b expected 1", timeout_err); else n_pass++;
    do_txn(10'd52, 10'd60, 0, 2, 8'd10, 0, 2, -1, r);
    n_chk++; if (r.pix !== 1'b1 || r.ans_cyc !== 5) $display("FAIL tmo_next_read: got pix %b cycle %0d expected 1 at 5", r.pix, r.ans_cyc); else n_pass++;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", timeout_err); else n_pass++;
  endtask

  task automatic test_stall_reset();
    res_t r;
    int n, ans_seen;
    do_txn(10'd300, 10'd200, 20, 3, 8'd200, 0, 2, -1, r);
    n_chk++; if (r.req_cnt !== 21 || r.req_cyc !== 2) $display("FAIL stall_req_window: got %0d cycles from %0d expected 21 from 2", r.req_cnt, r.req_cyc); else n_pass++;
    n_chk++; if (r.stable !== 1'b1 || r.addr !== 19'd128300) $display("FAIL stall_addr: got %0d stable %b expected 128300 stable 1", r.addr, r.stable); else n_pass++;
    n_chk++; if (r.ans_cyc !== 26 || r.pix !== 1'b0) $display("FAIL stall_answer: got cycle %0d pix %b expected 26 pix 0", r.ans_cyc, r.pix); else n_pass++;
    coordinate_x = 10'd33; coordinate_y = 10'd44; pt_req = 1'b1;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_chk++; if (n >= 20) $display("FAIL rst_wait_for_req: got no rd_req within 20 cycles"); else n_pass++;
    rd_ack = 1'b1; @(posedge clk); #1; rd_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; pt_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    n_chk++; if ({busy, rd_req, Ans_valid, timeout_err} !== 4'b0) $display("FAIL rst_in_wait: got busy/req/ans/err %b expected 0000", {busy, rd_req, Ans_valid, timeout_err}); else n_pass++;
    n_chk++; if (rd_addr !== 19'd0) $display("FAIL rst_in_wait_addr: got %0d expected 0", rd_addr); else n_pass++;
    rd_valid = 1'b1; rd_data = 8'd0;
    ans_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (Ans_valid === 1'b1) ans_seen++;
      @(posedge clk); #1; rd_valid = 1'b0;
    end
    n_chk++; if (ans_seen !== 0 || pt_pixl_value !== 1'b0) $display("FAIL rst_discard: got %0d answers pix %b expected 0 answers pix 0", ans_seen, pt_pixl_value); else n_pass++;
  endtask

  task automatic test_random();
    res_t r;
    logic [9:0] x, y;
    logic [7:0] d;
    int ad, vd, ed, exp_ans;
    logic exp_pix;
    bit oob;
    exp_pix = 1'b0;
    for (int it = 0; it < 40; it++) begin
      x  = 10'($urandom_range(0, 699));
      y  = 10'($urandom_range(0, 519));
      d  = 8'($urandom);
      ad = $urandom_range(0, 5);
      vd = $urandom_range(0, 6);
      ed = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : -1;
      rd_valid = 1'b1; rd_data = 8'($urandom);
      @(negedge clk);
      n_chk++; if (pt_pixl_value !== exp_pix) $display("FAIL rand_idle_valid_%0d: got %b expected %b", it, pt_pixl_value, exp_pix); else n_pass++;
      @(posedge clk); #1; rd_valid = 1'b0;
      do_txn(x, y, ad, vd, d, 0, 2, ed, r);
      oob = (x >= 10'd640) || (y >= 10'd480);
      if (oob) begin
        exp_pix = 1'b0;
        exp_ans = 2;
        n_chk++; if (r.req_cnt !== 0) $display("FAIL rand_oob_read_%0d: got %0d read cycles expected 0", it, r.req_cnt); else n_pass++;
      end else begin
        exp_pix = (d < 8'd128);
        exp_ans = 2 + ad + vd + 1;
        n_chk++; if (r.addr !== 19'(int'(y) * 640 + int'(x)) || r.req_cnt !== ad + 1)
          $display("FAIL rand_read_%0d: got addr %0d len %0d expected addr %0d len %0d", it, r.addr, r.req_cnt, int'(y) * 640 + int'(x), ad + 1); else n_pass++;
      end
      n_chk++; if (r.ans_cyc !== exp_ans || r.pix !== exp_pix)
        $display("FAIL rand_answer_%0d: got cycle %0d pix %b expected cycle %0d pix %b", it, r.ans_cyc, r.pix, exp_ans, exp_pix); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_rearm();
    test_out_of_range();
    test_timeout();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
